// File: rtl/ex_div_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_pkg
// Shared definitions for the EX-stage RV32M integer divider.
//   - div_op_e    : operation encoding, equal to funct3[1:0] of DIV/DIVU/REM/REMU
//   - div_state_e : divider FSM states
//   - DIV_CNT_W   : width of the iteration counter
//   - op_is_signed / op_is_rem : operation decode helpers
// ---------------------------------------------------------------------------
package ex_div_pkg;

   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   // DIV and REM treat their operands as two's-complement values.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   // REM and REMU return the remainder rather than the quotient.
   function automatic logic op_is_rem(input logic [1:0] op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/ex_div_if.sv
// ---------------------------------------------------------------------------
// ex_div_if
// Handshake/bus bundle between decode/pipeline control and the divider.
//   master (issue side): drives start_i, op_i, dividend_i, divisor_i,
//                        waddr_i, flush_i; observes busy_o, ready_o,
//                        result_o, reg_we_o, reg_waddr_o
//   slave  (divider)   : the mirror image of master
// ---------------------------------------------------------------------------
interface ex_div_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
);

   logic                   start_i;
   logic [1:0]             op_i;
   logic [DATA_WIDTH-1:0]  dividend_i;
   logic [DATA_WIDTH-1:0]  divisor_i;
   logic [RADDR_WIDTH-1:0] waddr_i;
   logic                   flush_i;
   logic                   busy_o;
   logic                   ready_o;
   logic [DATA_WIDTH-1:0]  result_o;
   logic                   reg_we_o;
   logic [RADDR_WIDTH-1:0] reg_waddr_o;

   modport master (
      output start_i, op_i, dividend_i, divisor_i, waddr_i, flush_i,
      input  busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
   );

   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, waddr_i, flush_i,
      output busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
   );

endinterface

// File: rtl/ex_div_step.sv
// ---------------------------------------------------------------------------
// ex_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem       : partial remainder (always < divisor on entry)
//   quot      : quotient register; its MSB is the next dividend bit to bring in
//   divisor   : divisor magnitude
//   next_rem  : partial remainder after this step
//   next_quot : quot shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module ex_div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic [DATA_WIDTH-1:0] quot,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] next_rem,
   output logic [DATA_WIDTH-1:0] next_quot
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;
   logic                borrow;

   // Because rem < divisor, the shifted value is below 2*divisor, so the top
   // bit of the (DATA_WIDTH+1)-bit difference is set exactly when the trial
   // subtraction went negative and the old value must be restored.
   assign shifted   = {rem, quot[DATA_WIDTH-1]};
   assign diff      = shifted - {1'b0, divisor};
   assign borrow    = diff[DATA_WIDTH];
   assign next_rem  = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
   assign next_quot = {quot[DATA_WIDTH-2:0], ~borrow};

endmodule

// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the EX stage. Runs a
// 32-step restoring division on operand magnitudes, fixes up signs at the
// end and returns quotient or remainder with a one-cycle write-enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ex_div_if.slave
//      start_i/op_i/dividend_i/divisor_i/waddr_i : launch request from decode
//      flush_i     : abort the in-flight operation
//      busy_o      : high whenever the FSM is not in IDLE
//      ready_o     : one-cycle result-valid pulse (reg_we_o mirrors it)
//      result_o    : quotient or remainder, held until the next completion
//      reg_waddr_o : rd address of the completed operation
// ---------------------------------------------------------------------------
module ex_div
   import ex_div_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
) (
   input logic       clk,
   input logic       rst_n,
   ex_div_if.slave   bus
);

   div_state_e             state;
   logic [DATA_WIDTH-1:0]  rem_q;
   logic [DATA_WIDTH-1:0]  quot_q;
   logic [DATA_WIDTH-1:0]  divisor_q;
   logic [DIV_CNT_W-1:0]   cnt_q;
   logic                   rem_sel_q;
   logic                   quot_neg_q;
   logic                   rem_neg_q;
   logic [RADDR_WIDTH-1:0] waddr_q;

   logic                   busy_q;
   logic                   ready_q;
   logic                   we_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic [RADDR_WIDTH-1:0] reg_waddr_q;

   logic                   signed_op;
   logic                   dividend_neg;
   logic                   divisor_neg;
   logic [DATA_WIDTH-1:0]  dividend_mag;
   logic [DATA_WIDTH-1:0]  divisor_mag;
   logic                   div_by_zero;
   logic                   sign_overflow;
   logic [DATA_WIDTH-1:0]  special_result;

   logic [DATA_WIDTH-1:0]  next_rem;
   logic [DATA_WIDTH-1:0]  next_quot;
   logic [DATA_WIDTH-1:0]  fixed_quot;
   logic [DATA_WIDTH-1:0]  fixed_rem;
   logic [DATA_WIDTH-1:0]  final_result;
   logic                   last_step;

   // Launch-side decode: operand magnitudes for the unsigned datapath and
   // the two operand combinations whose results are fixed by the ISA, which
   // bypass the iteration entirely.
   assign signed_op      = op_is_signed(bus.op_i);
   assign dividend_neg   = signed_op & bus.dividend_i[DATA_WIDTH-1];
   assign divisor_neg    = signed_op & bus.divisor_i[DATA_WIDTH-1];
   assign dividend_mag   = dividend_neg ? -bus.dividend_i : bus.dividend_i;
   assign divisor_mag    = divisor_neg  ? -bus.divisor_i  : bus.divisor_i;
   assign div_by_zero    = (bus.divisor_i == '0);
   assign sign_overflow  = signed_op
                         & (bus.dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                         & (bus.divisor_i == '1);
   assign special_result = op_is_rem(bus.op_i)
                         ? (div_by_zero ? bus.dividend_i : '0)
                         : (div_by_zero ? '1 : bus.dividend_i);

   ex_div_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .rem       (rem_q),
      .quot      (quot_q),
      .divisor   (divisor_q),
      .next_rem  (next_rem),
      .next_quot (next_quot)
   );

   // The final step's output feeds the sign fixup directly, so the result
   // is registered on the same edge that enters DONE and ready_o is high
   // for the whole DONE cycle.
   assign last_step    = (cnt_q == DIV_CNT_W'(DATA_WIDTH - 1));
   assign fixed_quot   = quot_neg_q ? -next_quot : next_quot;
   assign fixed_rem    = rem_neg_q  ? -next_rem  : next_rem;
   assign final_result = rem_sel_q ? fixed_rem : fixed_quot;

   // Divider FSM with all outputs registered. IDLE accepts a launch unless
   // flush is also present; special cases jump straight to DONE with the
   // result already in place. CALC runs one restoring step per cycle and a
   // flush there abandons the operation before any pulse. Because the pulse
   // is registered on entry to DONE, DONE itself always just returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DIV_IDLE;
         rem_q       <= '0;
         quot_q      <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
         rem_sel_q   <= 1'b0;
         quot_neg_q  <= 1'b0;
         rem_neg_q   <= 1'b0;
         waddr_q     <= '0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         result_q    <= '0;
         reg_waddr_q <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               if (bus.start_i && !bus.flush_i) begin
                  busy_q <= 1'b1;
                  if (div_by_zero || sign_overflow) begin
                     result_q    <= special_result;
                     reg_waddr_q <= bus.waddr_i;
                     ready_q     <= 1'b1;
                     we_q        <= 1'b1;
                     state       <= DIV_DONE;
                  end else begin
                     rem_sel_q  <= op_is_rem(bus.op_i);
                     quot_neg_q <= dividend_neg ^ divisor_neg;
                     rem_neg_q  <= dividend_neg;
                     waddr_q    <= bus.waddr_i;
                     divisor_q  <= divisor_mag;
                     quot_q     <= dividend_mag;
                     rem_q      <= '0;
                     cnt_q      <= '0;
                     state      <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               if (bus.flush_i) begin
                  busy_q <= 1'b0;
                  state  <= DIV_IDLE;
               end else if (last_step) begin
                  result_q    <= final_result;
                  reg_waddr_q <= waddr_q;
                  ready_q     <= 1'b1;
                  we_q        <= 1'b1;
                  state       <= DIV_DONE;
               end else begin
                  rem_q  <= next_rem;
                  quot_q <= next_quot;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            DIV_DONE: begin
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               state   <= DIV_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               state   <= DIV_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.ready_o     = ready_q;
   assign bus.reg_we_o    = we_q;
   assign bus.result_o    = result_q;
   assign bus.reg_waddr_o = reg_waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div
// Self-checking bench for ex_div: a vector table pushed through a scoreboard,
// a few random operations against a reference model, plus hand-written
// flush and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_ex_div;
   import ex_div_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [AW-1:0] wa;
      logic [DW-1:0] exp;
      int            lat;
   } vec_t;

   typedef struct {
      logic [DW-1:0] exp;
      logic [AW-1:0] wa;
      int            start;
      int            lat;
      int            tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   int   cycle_cnt = 0;
   int   pulse_count = 0;
   exp_t scoreboard[$];
   vec_t vecs[18];

   ex_div_if #(.DATA_WIDTH(DW), .RADDR_WIDTH(AW)) bus ();

   ex_div #(
      .DATA_WIDTH  (DW),
      .RADDR_WIDTH (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock and cycle counter used to measure latency.
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Watchdog so the run always ends even if the DUT wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
   endtask

   function automatic logic [DW-1:0] refDiv(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic signed [DW-1:0] sa;
      logic signed [DW-1:0] sd;
      sa = a;
      sd = b;
      case (op)
         DIV_OP_DIV:  return sa / sd;
         DIV_OP_DIVU: return a / b;
         DIV_OP_REM:  return sa % sd;
         default:     return a % b;
      endcase
   endfunction

   // Monitor: every ready_o pulse pops one expectation; a pulse with nothing
   // outstanding is itself an error.
   always @(negedge clk) begin
      if (rst_n && bus.ready_o) begin
         pulse_count++;
         if (scoreboard.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_ready: ready_o=1 at cycle %0d, required 0", cycle_cnt);
         end else begin
            exp_t e;
            e = scoreboard.pop_front();
            checkOutput($sformatf("result_t%0d", e.tag), bus.result_o, e.exp);
            checkOutput($sformatf("reg_we_t%0d", e.tag), 32'(bus.reg_we_o), 32'd1);
            checkOutput($sformatf("waddr_t%0d", e.tag), 32'(bus.reg_waddr_o), 32'(e.wa));
            checkOutput($sformatf("latency_t%0d", e.tag), 32'(cycle_cnt - e.start), 32'(e.lat));
         end
      end
   end

   // All tasks below start and end #1 after a rising edge.
   task automatic waitCycle(input int target);
      while (cycle_cnt < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] wa,
                        input bit track, input logic [DW-1:0] exp,
                        input int lat, input int tag,
                        output int start_c, output bit ok);
      int waited = 0;
      while (bus.busy_o !== 1'b0 && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      ok = (bus.busy_o === 1'b0);
      start_c = cycle_cnt;
      if (!ok) begin
         checks++;
         $display("[TB] FAIL idle_wait_t%0d: busy_o=%b after %0d cycles, required 0", tag, bus.busy_o, waited);
         return;
      end
      bus.op_i       = op;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      bus.waddr_i    = wa;
      bus.start_i    = 1'b1;
      if (track) scoreboard.push_back('{exp: exp, wa: wa, start: start_c, lat: lat, tag: tag});
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int tag);
      int  start_c;
      bit  ok;
      issue(v.op, v.a, v.b, v.wa, 1'b1, v.exp, v.lat, tag, start_c, ok);
      if (ok) checkOutput($sformatf("busy_after_start_t%0d", tag), 32'(bus.busy_o), 32'd1);
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((scoreboard.size() != 0 || bus.busy_o !== 1'b0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain", 32'(scoreboard.size() == 0 && bus.busy_o === 1'b0), 32'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},  32'(bus.busy_o),      32'd0);
      checkOutput({tag, "_ready"}, 32'(bus.ready_o),     32'd0);
      checkOutput({tag, "_we"},    32'(bus.reg_we_o),    32'd0);
      checkOutput({tag, "_result"}, bus.result_o,        32'd0);
      checkOutput({tag, "_waddr"}, 32'(bus.reg_waddr_o), 32'd0);
   endtask

   initial begin
      int   start_c;
      bit   ok;
      int   pulses_before;
      vec_t v;

      vecs[0]  = '{DIV_OP_DIV,  32'd20,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFFA, 33};
      vecs[1]  = '{DIV_OP_REM,  32'd20,        32'hFFFFFFFD, 5'd2,  32'd2,        33};
      vecs[2]  = '{DIV_OP_DIVU, 32'hFFFFFFFF,  32'd10,       5'd7,  32'h19999999, 33};
      vecs[3]  = '{DIV_OP_REMU, 32'hFFFFFFFF,  32'd10,       5'd7,  32'd5,        33};
      vecs[4]  = '{DIV_OP_DIVU, 32'hDEADBEEF,  32'd0,        5'd3,  32'hFFFFFFFF, 1};
      vecs[5]  = '{DIV_OP_REM,  32'h00001234,  32'd0,        5'd4,  32'h00001234, 1};
      vecs[6]  = '{DIV_OP_DIV,  32'h80000000,  32'hFFFFFFFF, 5'd5,  32'h80000000, 1};
      vecs[7]  = '{DIV_OP_REM,  32'h80000000,  32'hFFFFFFFF, 5'd6,  32'd0,        1};
      vecs[8]  = '{DIV_OP_DIV,  32'hFFFFFFEC,  32'd3,        5'd8,  32'hFFFFFFFA, 33};
      vecs[9]  = '{DIV_OP_REM,  32'hFFFFFFEC,  32'd3,        5'd9,  32'hFFFFFFFE, 33};
      vecs[10] = '{DIV_OP_DIV,  32'hFFFFFFF9,  32'hFFFFFFFE, 5'd10, 32'd3,        33};
      vecs[11] = '{DIV_OP_REM,  32'hFFFFFFF9,  32'hFFFFFFFE, 5'd11, 32'hFFFFFFFF, 33};
      vecs[12] = '{DIV_OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 5'd12, 32'd0,        33};
      vecs[13] = '{DIV_OP_REMU, 32'h80000000,  32'hFFFFFFFF, 5'd13, 32'h80000000, 33};
      vecs[14] = '{DIV_OP_DIV,  32'h80000000,  32'd1,        5'd14, 32'h80000000, 33};
      vecs[15] = '{DIV_OP_DIV,  32'd0,         32'd5,        5'd15, 32'd0,        33};
      vecs[16] = '{DIV_OP_REMU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd31, 32'd0,        33};
      vecs[17] = '{DIV_OP_DIVU, 32'd7,         32'd9,        5'd0,  32'd0,        33};

      rst_n          = 1'b0;
      bus.start_i    = 1'b0;
      bus.op_i       = 2'b00;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      bus.waddr_i    = '0;
      bus.flush_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] vector table");
      for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);
      waitDrain();

      $display("[TB] random operations");
      for (int i = 0; i < 8; i++) begin
         v.op = 2'(i % 4);
         v.a  = $urandom;
         v.b  = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (v.b == 0) v.b = 1;
         if (op_is_signed(v.op) && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 2;
         v.wa  = 5'(i + 16);
         v.exp = refDiv(v.op, v.a, v.b);
         v.lat = 33;
         applyStimulus(v, 100 + i);
      end
      waitDrain();

      $display("[TB] flush sequence");
      pulses_before = pulse_count;
      issue(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b0, '0, 0, 200, start_c, ok);
      waitCycle(start_c + 5);
      bus.op_i       = DIV_OP_DIVU;
      bus.dividend_i = 32'd50;
      bus.divisor_i  = 32'd0;
      bus.start_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      waitCycle(start_c + 10);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      checkOutput("flush_busy", 32'(bus.busy_o), 32'd0);
      checkOutput("flush_ready", 32'(bus.ready_o), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("flush_no_pulse", 32'(pulse_count - pulses_before), 32'd0);

      $display("[TB] flush with start in idle");
      pulses_before = pulse_count;
      bus.op_i       = DIV_OP_DIVU;
      bus.dividend_i = 32'd9;
      bus.divisor_i  = 32'd0;
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      checkOutput("flush_start_busy", 32'(bus.busy_o), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("flush_start_no_pulse", 32'(pulse_count - pulses_before), 32'd0);

      $display("[TB] reset during operation");
      issue(DIV_OP_DIVU, 32'h0FFFFFFF, 32'd3, 5'd21, 1'b0, '0, 0, 300, start_c, ok);
      waitCycle(start_c + 20);
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      pulses_before = pulse_count;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("midreset_no_pulse", 32'(pulse_count - pulses_before), 32'd0);
      applyStimulus('{DIV_OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 33}, 301);
      waitDrain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
